// File: rtl/cf_fft_pkg.sv
// Shared definitions for the streaming FFT pipeline: default sizes, bank
// encoding and the bit-reverse helper used for reordered readout.
package cf_fft_pkg;

  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned AW_DEF       = 8;
  // Widest address the bit-reverse helper supports.
  localparam int unsigned BITREV_MAX_W = 16;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_t;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(
    input logic [BITREV_MAX_W-1:0] v,
    input int unsigned             w
  );
    logic [BITREV_MAX_W-1:0] r;
    r = {<<{v}};
    return r >> (BITREV_MAX_W - w);
  endfunction

endpackage : cf_fft_pkg

// File: rtl/cf_fft_dpram.sv
// Simple dual-port RAM for one ping-pong bank: synchronous write port and a
// read port driven from an address that the caller already holds in a register.
module cf_fft_dpram
  import cf_fft_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clock_c,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data_c
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Sample storage; contents are never reset.
  always_ff @(posedge clock_c) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule : cf_fft_dpram

// File: rtl/cf_fft_pingpong_buf.sv
// Ping-pong reorder buffer between FFT stages. One bank is written at
// arbitrary addresses while the other is read back; banks swap every DEPTH
// ce-qualified cycles. Define CF_FFT_BITREV_RD_EN for bit-reversed readout.
module cf_fft_pingpong_buf
  import cf_fft_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clock_c,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          sync,
  input  logic          ce,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          bank_sel,
  output logic          frame_err
);

  localparam int unsigned DEPTH     = 1 << AW;
  localparam logic [AW:0] WCNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

  logic [AW-1:0] rd_cnt;
  bank_t         wbank;
  logic [AW:0]   wcnt;
  logic          primed;
  logic [AW-1:0] rd_addr_q;
  bank_t         rbank_q;
  logic          valid_q;
  logic          err;

  logic          wr_fire_c;
  logic          wr_bank0_c;
  logic          wr_bank1_c;
  logic          last_c;
  logic [AW:0]   wcnt_inc_c;
  logic [AW-1:0] rd_addr_nxt_c;
  logic [DW-1:0] bank0_data_c;
  logic [DW-1:0] bank1_data_c;

  // Writes only land on plain enabled cycles; clr and sync drop them.
  assign wr_fire_c  = ce & wr_en & ~clr & ~sync;
  assign wr_bank0_c = wr_fire_c & (wbank == BANK0);
  assign wr_bank1_c = wr_fire_c & (wbank == BANK1);

  // Final write count for this cycle, saturating at a full frame.
  assign wcnt_inc_c = (wr_en && (wcnt != WCNT_FULL)) ? wcnt + (AW+1)'(1) : wcnt;
  assign last_c     = (rd_cnt == CNT_LAST);

`ifdef CF_FFT_BITREV_RD_EN
  assign rd_addr_nxt_c = AW'(bitrev(BITREV_MAX_W'(rd_cnt), AW));
`else
  assign rd_addr_nxt_c = rd_cnt;
`endif

  // Frame counters, bank swap, read pipeline and sticky fill-error flag.
  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt    <= '0;
      wbank     <= BANK0;
      wcnt      <= '0;
      primed    <= 1'b0;
      rd_addr_q <= '0;
      rbank_q   <= BANK0;
      valid_q   <= 1'b0;
      err       <= 1'b0;
    end else if (clr) begin
      rd_cnt  <= '0;
      wbank   <= BANK0;
      wcnt    <= '0;
      primed  <= 1'b0;
      rbank_q <= BANK0;
      valid_q <= 1'b0;
      err     <= 1'b0;
    end else if (sync) begin
      rd_cnt  <= '0;
      wbank   <= BANK0;
      wcnt    <= '0;
      primed  <= 1'b0;
      rbank_q <= BANK0;
      valid_q <= 1'b0;
    end else if (ce) begin
      rd_addr_q <= rd_addr_nxt_c;
      rbank_q   <= bank_t'(~wbank);
      valid_q   <= primed;
      rd_cnt    <= rd_cnt + AW'(1);
      if (last_c) begin
        wbank  <= (wbank == BANK0) ? BANK1 : BANK0;
        primed <= 1'b1;
        wcnt   <= '0;
        if (wcnt_inc_c != WCNT_FULL) begin
          err <= 1'b1;
        end
      end else begin
        wcnt <= wcnt_inc_c;
      end
    end
  end

  cf_fft_dpram #(.DW(DW), .AW(AW)) u_bank0 (
    .clock_c   (clock_c),
    .we        (wr_bank0_c),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr_q),
    .rd_data_c (bank0_data_c)
  );

  cf_fft_dpram #(.DW(DW), .AW(AW)) u_bank1 (
    .clock_c   (clock_c),
    .we        (wr_bank1_c),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr_q),
    .rd_data_c (bank1_data_c)
  );

  // Output bank select from the registered read bank.
  assign rd_data   = (rbank_q == BANK1) ? bank1_data_c : bank0_data_c;
  assign rd_valid  = valid_q;
  assign bank_sel  = wbank;
  assign frame_err = err;

endmodule : cf_fft_pingpong_buf

// File: tb/tb_cf_fft_pingpong_buf.sv
// Directed bench for cf_fft_pingpong_buf with AW=3. Expected read order
// follows CF_FFT_BITREV_RD_EN so the same bench covers both builds.
module tb_cf_fft_pingpong_buf;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clock_c = 1'b0;
  logic          reset_n;
  logic          clr;
  logic          sync;
  logic          ce;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          bank_sel;
  logic          frame_err;

  int checks = 0;
  int errors = 0;
  int ord [DEPTH];

  cf_fft_pingpong_buf #(.DW(DW), .AW(AW)) dut (
    .clock_c   (clock_c),
    .reset_n   (reset_n),
    .clr       (clr),
    .sync      (sync),
    .ce        (ce),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .bank_sel  (bank_sel),
    .frame_err (frame_err)
  );

  always #5 clock_c = ~clock_c;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one clock cycle of inputs, then settle just after the edge.
  task automatic step(input logic c, input logic s, input logic e, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    clr     = c;
    sync    = s;
    ce      = e;
    wr_en   = w;
    wr_addr = a;
    wr_data = d;
    @(posedge clock_c);
    #1;
  endtask

  // Check outputs expected after ce-qualified cycle n of a run started by sync.
  task automatic chk_after(input string name, input int n, input logic [DW-1:0] base);
    logic exp_bank;
    logic exp_valid;
    exp_bank  = 1'(((n + 1) / DEPTH) % 2);
    exp_valid = (n >= DEPTH);
    chk($sformatf("%s bank n=%0d", name, n), DW'(bank_sel), DW'(exp_bank));
    chk($sformatf("%s valid n=%0d", name, n), DW'(rd_valid), DW'(exp_valid));
    if (n >= DEPTH) begin
      chk($sformatf("%s data n=%0d", name, n), rd_data,
          base + DW'(32'h100 * ((n - DEPTH) / DEPTH)) + DW'(ord[n % DEPTH]));
    end
  endtask

  // Sync, then write nframes full frames (base + 0x100*f + k at addr k).
  // With gate set, a ce=0 cycle carrying a junk write follows every ce cycle.
  task automatic run_frames(input string name, input int nframes,
                            input logic [DW-1:0] base, input logic gate);
    step(1'b0, 1'b1, 1'b1, 1'b1, '0, 32'hBAD0_BAD0);
    chk({name, " sync valid"}, DW'(rd_valid), '0);
    chk({name, " sync bank"}, DW'(bank_sel), '0);
    for (int n = 0; n < nframes * DEPTH; n++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, AW'(n % DEPTH),
           base + DW'(32'h100 * (n / DEPTH)) + DW'(n % DEPTH));
      chk_after(name, n, base);
      if (gate) begin
        step(1'b0, 1'b0, 1'b0, 1'b1, AW'((n + 3) % DEPTH), 32'hDEAD_BEEF);
        chk_after({name, " hold"}, n, base);
      end
    end
  endtask

  initial begin
`ifdef CF_FFT_BITREV_RD_EN
    ord = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    ord = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    reset_n = 1'b0;
    clr = 1'b0; sync = 1'b0; ce = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #23;
    chk("reset valid", DW'(rd_valid), '0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("idle valid", DW'(rd_valid), '0);
    chk("idle bank", DW'(bank_sel), '0);
    chk("idle err", DW'(frame_err), '0);

    // Three back-to-back frames; the first two are read out fully.
    run_frames("seq", 3, 32'h100, 1'b0);
    chk("seq err", DW'(frame_err), '0);

    // Same traffic with ce toggling and junk writes on disabled cycles.
    run_frames("gate", 3, 32'h700, 1'b1);
    chk("gate err", DW'(frame_err), '0);

    // Short frame: 7 writes, error on the swap edge, sticky through sync.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
    for (int n = 0; n < DEPTH; n++) begin
      step(1'b0, 1'b0, 1'b1, (n != DEPTH - 1), AW'(n), 32'h300 + DW'(n));
      if (n == DEPTH - 2) chk("short err pre", DW'(frame_err), '0);
    end
    chk("short err swap", DW'(frame_err), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
    chk("short err after sync", DW'(frame_err), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("short err after clr", DW'(frame_err), '0);
    chk("clr valid", DW'(rd_valid), '0);
    chk("clr bank", DW'(bank_sel), '0);

    // Mid-frame sync: a frame plus five cycles, then restart.
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
    for (int n = 0; n < DEPTH + 5; n++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, AW'(n % DEPTH), 32'h400 + DW'(32'h100 * (n / DEPTH)) + DW'(n % DEPTH));
    end
    chk("mid valid before", DW'(rd_valid), 32'd1);
    chk("mid bank before", DW'(bank_sel), 32'd1);
    run_frames("mid", 2, 32'h800, 1'b0);
    chk("mid err", DW'(frame_err), '0);

    // clr and sync together: clr wins and clears the sticky error.
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
    for (int n = 0; n < DEPTH; n++) begin
      step(1'b0, 1'b0, 1'b1, (n != 2), AW'(n), 32'h900 + DW'(n));
    end
    chk("coll err set", DW'(frame_err), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1, '0, '0);
    chk("coll err clr", DW'(frame_err), '0);
    chk("coll valid", DW'(rd_valid), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cf_fft_pingpong_buf
